// File: rtl/per_rom_loader.sv
// Boot-time ROM loader: packs a little-endian byte stream into 32-bit words and
// writes them to consecutive ROM word slots through registered device strobes.

`ifndef SelectModeBus
`define SelectModeBus 1:0
`endif
`ifndef SelectAsDevice
`define SelectAsDevice 2'b10
`endif
`ifndef RWInoutW
`define RWInoutW 1'b1
`endif
`ifndef RWInoutR
`define RWInoutR 1'b0
`endif

module per_rom_loader #(
    parameter int WORDS   = 64,
    parameter int TIMEOUT = 1000000,
    parameter int ADDR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [6:0]            len_in,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [`SelectModeBus] select_as_out,
    output logic                  rw_out,
    output logic [ADDR_W-1:0]     addr_out,
    output logic [31:0]           data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           checksum
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [6:0]       WORDS_L  = 7'(WORDS);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      word_idx_q, word_idx_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [6:0]            len_q, len_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [31:0]           data_q, data_d;
    logic [31:0]           csum_q, csum_d;
    logic [`SelectModeBus] sel_q, sel_d;
    logic                  rw_q, rw_d;

    logic       xfer;
    logic       last_word;
    logic       can_start;
    logic [6:0] len_clamped;

    assign xfer        = byte_valid && (state_q == S_COLLECT);
    assign last_word   = (7'(word_idx_q) + 7'd1) == len_q;
    assign can_start   = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
    // A zero or oversized length loads the whole ROM, so word_idx never wraps mid-load.
    assign len_clamped = ((len_in == 7'd0) || (len_in > WORDS_L)) ? WORDS_L : len_in;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            timer_q    <= '0;
            data_q     <= '0;
            csum_q     <= '0;
            sel_q      <= '0;
            rw_q       <= `RWInoutR;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            timer_q    <= timer_d;
            data_q     <= data_d;
            csum_q     <= csum_d;
            sel_q      <= sel_d;
            rw_q       <= rw_d;
        end
    end

    // NOTE: every next-state value is defaulted first so no branch can infer a latch.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        timer_d    = timer_q;
        data_d     = data_q;
        csum_d     = csum_q;
        sel_d      = '0;
        rw_d       = `RWInoutR;

        if (can_start && start) begin
            state_d    = S_COLLECT;
            word_idx_d = '0;
            byte_cnt_d = '0;
            csum_d     = '0;
            timer_d    = '0;
            len_d      = len_clamped;
        end else begin
            unique case (state_q)
                S_COLLECT: begin
                    if (xfer) begin
                        data_d[8*byte_cnt_q +: 8] = byte_in;
                        byte_cnt_d                = byte_cnt_q + 2'd1;
                        timer_d                   = '0;
                        // Strobes are registered here so they are high exactly during WRITE.
                        if (byte_cnt_q == 2'd3) begin
                            state_d = S_WRITE;
                            sel_d   = `SelectAsDevice;
                            rw_d    = `RWInoutW;
                        end
                    end else if (timer_q == TMR_LAST) begin
                        state_d = S_ERROR;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    csum_d     = csum_q ^ data_q;
                    byte_cnt_d = '0;
                    if (last_word) begin
                        state_d = S_DONE;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                        state_d    = S_COLLECT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_ready    = (state_q == S_COLLECT);
    assign busy          = (state_q == S_COLLECT) || (state_q == S_WRITE);
    assign done          = (state_q == S_DONE);
    assign error         = (state_q == S_ERROR);
    assign select_as_out = sel_q;
    assign rw_out        = rw_q;
    assign addr_out      = ADDR_W'({word_idx_q, 2'b00});
    assign data_out      = data_q;
    assign checksum      = csum_q;

endmodule

// File: doc/per_rom_loader.md
Name: per_rom_loader

Overview:
- Boot-time loader that sits directly upstream of the ROM peripheral on the XSimBus device side.
- Accepts a byte stream (for example from the UART receiver) and packs every 4 bytes little-endian into a 32-bit word.
- Writes each word into consecutive ROM word slots using single-cycle device write strobes.
- Reports completion, a running XOR checksum, and a timeout error; the core is held off until `done` is asserted.

Parameters:
- WORDS, 64, ROM depth in words; also the word count used when len_in==0.
- TIMEOUT, 1000000, maximum clk cycles allowed between bytes while loading before an error is raised.
- ADDR_W, 8, width of addr_out; byte address, word index carried in bits [7:2].

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- start  in  1  one-cycle pulse; begins a load (accepted in IDLE, DONE and ERROR only).
- len_in  in  7  number of words to load, sampled on start; 0 means WORDS; values >WORDS are clamped to WORDS.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  loader accepts byte this cycle; a transfer occurs when valid&&ready.
- select_as_out  out  `SelectModeBus  `SelectAsDevice during a write cycle, all-zero otherwise.
- rw_out  out  1  `RWInoutW during a write cycle, `RWInoutR otherwise.
- addr_out  out  ADDR_W  {word_idx, 2'b00}.
- data_out  out  32  packed word.
- busy  out  1  high in COLLECT or WRITE.
- done  out  1  high in DONE.
- error  out  1  high in ERROR.
- checksum  out  32  XOR of all words written in the current load.

Behaviour:
- States:
  - IDLE: byte_ready=0; on start go to COLLECT, clear word_idx/byte_cnt/checksum/timer, latch len.
  - COLLECT: byte_ready=1. On each transfer, byte k (k=byte_cnt 0..3) goes to data_out[8k+7:8k], byte_cnt++, timer cleared. After the 4th byte go to WRITE next cycle.
  - WRITE: exactly one cycle; byte_ready=0, select_as_out=`SelectAsDevice, rw_out=`RWInoutW, addr_out={word_idx,2'b00}, data_out=packed word. The ROM captures the word on this edge. Then checksum^=data_out, word_idx++, byte_cnt=0. If word_idx+1==len go to DONE, else go to COLLECT.
  - DONE: done=1, byte_ready=0; start restarts a load.
  - ERROR: error=1, byte_ready=0; start restarts a load; nothing else leaves ERROR except rst.
- Timeout: the timer counts every COLLECT cycle without a transfer. When timer reaches TIMEOUT-1 with no transfer, go to ERROR. A partial word is discarded, already-written words are kept, and checksum holds its value.
- start while busy is ignored.
- Latency: 4 accepted bytes, then 1 WRITE cycle. Maximum throughput is 1 word per 5 cycles.
- Reset values: state=IDLE; byte_ready=0; select_as_out=0; rw_out=`RWInoutR; addr_out=0; data_out=0; busy=done=error=0; checksum=0; all counters 0.
- rst mid-load returns to IDLE immediately (asynchronous). Words already in the ROM are untouched.
- Write strobe outputs are registered; no combinational path exists from byte_valid to select_as_out.
- word_idx is 6 bits for WORDS=64 and never wraps, because len is clamped to WORDS.

Test Plan:
- Reset then start, len_in=1, bytes 0x78,0x56,0x34,0x12 -> one WRITE cycle: addr_out=0x00, data_out=0x12345678, rw_out=W; then done=1, checksum=0x12345678; ROM read at 0x00 returns 0x12345678.
- len_in=3, bytes 00..0B, byte_valid toggled every other cycle -> writes at 0x00/0x04/0x08 = 0x03020100/0x07060504/0x0B0A0908; checksum = XOR of the three words; exactly 3 write strobes.
- len_in=0 with 256 bytes -> 64 writes, last at addr 0xFC; done asserted; byte_ready low afterwards even with byte_valid high.
- TIMEOUT=16, send 2 bytes then stall -> error=1 exactly 16 cycles after the last transfer; no write strobe for the partial word; a new start reloads from addr 0.
- Assert rst for 1 cycle mid-word (after 2 bytes) -> outputs return to reset values asynchronously; no write issued; start then works normally.
- Pulse start while busy, and pulse start in DONE -> the busy pulse is ignored; the DONE pulse restarts the load with checksum cleared to 0.
